fetch_stage: RTL

- Instruction-fetch front end of the pipeline.
- Generates the PC and issues reads to the 1-cycle-latency instruction memory.
- Buffers the returned 16-bit words in a small skid FIFO and presents one instruction per cycle to the downstream stall queue.
- Honours downstream `stall`, redirects on `flush`, and stops fetching after a halt word.

---
 rtl/fetch_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, 1-cycle imem reads, skid FIFO
// toward the downstream stall queue, with flush redirect and halt detection.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          SKID_DEPTH = 2,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  output logic        mem_ren,
  output logic [15:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic [15:0] out_instruction,
  output logic [15:0] out_pc,
  output logic        halted
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(SKID_DEPTH - 1);
  localparam logic [CW:0]   DEPTH = (CW+1)'(SKID_DEPTH);

  logic [15:0]   pc, inflight_pc;
  logic          inflight, kill;
  logic [15:0]   instr_q [SKID_DEPTH];
  logic [15:0]   pc_q    [SKID_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          pop, push, is_halt;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & ~stall & ~flush;
  assign push      = inflight & ~kill & ~flush;
  assign is_halt   = (mem_rdata == HALT_WORD);
  // Slots already committed after this cycle: buffered + returning - leaving.
  assign occ       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign mem_ren   = ~rst & ~flush & ~halted & (occ < DEPTH);
  assign mem_raddr = pc;

  assign out_instruction = out_valid ? instr_q[head] : '0;
  assign out_pc          = out_valid ? pc_q[head]    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
      halted      <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (flush) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      kill     <= inflight;
      halted   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= mem_ren;
      if (mem_ren) begin
        inflight_pc <= pc;
        pc          <= pc + 16'd1;
      end
      // A halt word drops the speculative read issued alongside it.
      kill <= push & is_halt;
      if (push && is_halt) halted <= 1'b1;
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_q[tail] <= mem_rdata;
      pc_q[tail]    <= inflight_pc;
    end
  end

`ifndef SYNTHESIS
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CW'(SKID_DEPTH)));
`endif

endmodule
